// File: rtl/bcd_2_bin_seq.sv
// Sequential BCD-to-binary converter.
// Three-digit BCD input (000..999) is converted to an 8-bit binary value using
// reverse double-dabble, one bit per clock over eight SHIFT cycles. Values above
// 255 wrap modulo 256 and raise err; any non-decimal digit aborts immediately
// with bin=0 and err=1.
module bcd_2_bin_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic [7:0] bin,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_bcd;     // BCD digits being drained, {hundreds,tens,ones}
  logic [7:0]  r_sh;      // binary result accumulates from the MSB side
  logic [3:0]  r_cnt;     // number of shift steps already performed

  logic [19:0] w_step;
  logic        w_digits_ok;

  // A nibble that reached 8 or more after a right shift came from a decade
  // digit >= 1 on the left; subtracting 3 turns the binary half-weight (8)
  // into the decimal half-weight (5).
  function automatic logic [3:0] nibble_adj(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  // One reverse-double-dabble step on the concatenated {bcd,binary} register.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] s;
    s         = v >> 1;
    s[19:16]  = nibble_adj(s[19:16]);
    s[15:12]  = nibble_adj(s[15:12]);
    s[11:8]   = nibble_adj(s[11:8]);
    return s;
  endfunction

  assign w_step      = dabble_step({r_bcd, r_sh});
  assign w_digits_ok = (hundreds <= 4'd9) && (tens <= 4'd9) && (ones <= 4'd9);

  // Control FSM plus datapath; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bcd   <= 12'd0;
      r_sh    <= 8'd0;
      r_cnt   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin     <= 8'd0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_bcd <= {hundreds, tens, ones};
            r_sh  <= 8'd0;
            r_cnt <= 4'd0;
            if (w_digits_ok) begin
              r_state <= S_SHIFT;
              busy    <= 1'b1;
            end else begin
              // Non-decimal digit: report at once, nothing to shift.
              r_state <= S_DONE;
              done    <= 1'b1;
              bin     <= 8'd0;
              err     <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          r_bcd <= w_step[19:8];
          r_sh  <= w_step[7:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            // Eighth step: anything left in the BCD part means V > 255.
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bin     <= w_step[7:0];
            err     <= |w_step[19:8];
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
